fp_mult_arbiter: RTL

- Shares one floating_point_mult_valid_only instance (fixed latency, valid-only, no backpressure) among G_NUM_REQ requesters, e.g. several polynomial estimator lanes.
- Round-robin arbitrates valid/ready requests onto the multiplier and tags each issue with the requester index.
- Routes each product back to its requester through a per-requester response FIFO with valid/ready.
- Credit accounting guarantees a product never arrives at a full FIFO. The multiplier is instantiated by the parent and connected through the mult_* ports.

---
 rtl/fp_mult_arbiter.sv | 203 ++++++++++++++++++++
 1 files changed

// File: rtl/fp_mult_arbiter.sv
// fp_mult_arbiter: shares one fixed-latency, valid-only floating-point
// multiplier among G_NUM_REQ requesters. A round-robin arbiter issues one
// request per cycle. A tag pipeline follows each issue through the
// multiplier, and every product is steered into that requester's
// first-word-fall-through response FIFO. Credits count FIFO entries plus
// products still in flight, so a product never reaches a full FIFO.
//
// Handshake: on both the request side and the response side, a transfer
// happens on a rising clk edge where valid and ready are both 1. The request
// side may raise ready combinationally from valid. The response side holds
// data stable while valid is 1 and it is not yet accepted. ready never
// depends combinationally on the other side of the block.
module fp_mult_arbiter #(
  parameter int G_NUM_REQ      = 4,
  parameter int G_MULT_LATENCY = 6,
  parameter int G_RESP_DEPTH   = 4
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic                      enable,
  input  logic [32*G_NUM_REQ-1:0]   req_din1,
  input  logic [32*G_NUM_REQ-1:0]   req_din2,
  input  logic [G_NUM_REQ-1:0]      req_valid,
  output logic [G_NUM_REQ-1:0]      req_ready,
  output logic [32*G_NUM_REQ-1:0]   rsp_dout,
  output logic [G_NUM_REQ-1:0]      rsp_valid,
  input  logic [G_NUM_REQ-1:0]      rsp_ready,
  output logic [31:0]               mult_din1,
  output logic [31:0]               mult_din2,
  output logic                      mult_din_valid,
  input  logic [31:0]               mult_dout,
  input  logic                      mult_dout_valid,
  output logic                      err_sync
);

  localparam int N  = G_NUM_REQ;
  localparam int L  = G_MULT_LATENCY;
  localparam int D  = G_RESP_DEPTH;
  localparam int IW = $clog2(N);
  localparam int AW = $clog2(D);
  localparam int CW = $clog2(D + 1);

  // arbitration
  logic [IW-1:0] rr_ptr;
  logic [IW-1:0] gnt_idx;
  logic [IW:0]   cand_sum;
  logic          accept;
  logic [N-1:0]  eligible;
  logic [CW:0]   occ;
  logic [31:0]   sel_din1;
  logic [31:0]   sel_din2;
  logic [IW-1:0] mult_idx;

  // tag pipeline: entry L-1 lines up with the multiplier output
  logic [L-1:0]  tag_v;
  logic [IW-1:0] tag_i [L];
  logic          exit_v;
  logic [IW-1:0] exit_i;

  // per-requester bookkeeping
  logic [CW-1:0] fifo_cnt [N];
  logic [CW-1:0] inflight [N];
  logic [AW-1:0] wr_ptr   [N];
  logic [AW-1:0] rd_ptr   [N];
  logic [31:0]   fifo_mem [N][D];
  logic [N-1:0]  inc_v;
  logic [N-1:0]  dec_v;
  logic [N-1:0]  wr_v;
  logic [N-1:0]  pop_v;

  assign exit_v = tag_v[L-1];
  assign exit_i = tag_i[L-1];

  // A requester may be granted only if it has a free credit and the block is enabled.
  always_comb begin
    eligible = '0;
    occ      = '0;
    for (int i = 0; i < N; i++) begin
      occ         = {1'b0, fifo_cnt[i]} + {1'b0, inflight[i]};
      eligible[i] = reset_n & enable & req_valid[i] & (occ < (CW+1)'(D));
    end
  end

  // Round-robin scan from rr_ptr upward; the first eligible requester wins.
  always_comb begin
    accept    = 1'b0;
    gnt_idx   = '0;
    req_ready = '0;
    cand_sum  = '0;
    for (int k = 0; k < N; k++) begin
      cand_sum = {1'b0, rr_ptr} + (IW+1)'(k);
      if (cand_sum >= (IW+1)'(N)) cand_sum = cand_sum - (IW+1)'(N);
      if (!accept && eligible[cand_sum[IW-1:0]]) begin
        accept  = 1'b1;
        gnt_idx = cand_sum[IW-1:0];
      end
    end
    if (accept) req_ready[gnt_idx] = 1'b1;
  end

  // Select the granted requester's operands.
  always_comb begin
    sel_din1 = '0;
    sel_din2 = '0;
    for (int i = 0; i < N; i++) begin
      if (IW'(i) == gnt_idx) begin
        sel_din1 = req_din1[32*i +: 32];
        sel_din2 = req_din2[32*i +: 32];
      end
    end
  end

  // Register the issue to the multiplier and advance the pointer past the winner.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mult_din1      <= '0;
      mult_din2      <= '0;
      mult_din_valid <= 1'b0;
      mult_idx       <= '0;
      rr_ptr         <= '0;
    end else begin
      mult_din_valid <= accept;
      if (accept) begin
        mult_din1 <= sel_din1;
        mult_din2 <= sel_din2;
        mult_idx  <= gnt_idx;
        rr_ptr    <= (gnt_idx == IW'(N - 1)) ? '0 : gnt_idx + IW'(1);
      end
    end
  end

  // Shift the {valid, index} tag alongside the multiplier's internal pipeline.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      tag_v <= '0;
      for (int s = 0; s < L; s++) tag_i[s] <= '0;
    end else begin
      tag_v[0] <= mult_din_valid;
      tag_i[0] <= mult_idx;
      for (int s = 1; s < L; s++) begin
        tag_v[s] <= tag_v[s-1];
        tag_i[s] <= tag_i[s-1];
      end
    end
  end

  // Per-requester strobes: issue, tag exit, FIFO write and FIFO pop.
  always_comb begin
    inc_v = '0;
    dec_v = '0;
    wr_v  = '0;
    pop_v = '0;
    for (int i = 0; i < N; i++) begin
      inc_v[i] = accept && (gnt_idx == IW'(i));
      dec_v[i] = exit_v && (exit_i == IW'(i));
      wr_v[i]  = dec_v[i] & mult_dout_valid;
      pop_v[i] = rsp_valid[i] & rsp_ready[i];
    end
  end

  // Counters and pointers; issue, write and pop in one cycle combine into a net change.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < N; i++) begin
        fifo_cnt[i] <= '0;
        inflight[i] <= '0;
        wr_ptr[i]   <= '0;
        rd_ptr[i]   <= '0;
      end
    end else begin
      for (int i = 0; i < N; i++) begin
        inflight[i] <= inflight[i] + CW'(inc_v[i]) - CW'(dec_v[i]);
        fifo_cnt[i] <= fifo_cnt[i] + CW'(wr_v[i]) - CW'(pop_v[i]);
        if (wr_v[i])  wr_ptr[i] <= wr_ptr[i] + AW'(1);
        if (pop_v[i]) rd_ptr[i] <= rd_ptr[i] + AW'(1);
      end
    end
  end

  // FIFO storage holds only data, so it needs no reset.
  always_ff @(posedge clk) begin
    for (int i = 0; i < N; i++) begin
      if (wr_v[i]) fifo_mem[i][wr_ptr[i]] <= mult_dout;
    end
  end

  // Fall-through read port; data is forced to zero while a FIFO is empty.
  always_comb begin
    rsp_valid = '0;
    rsp_dout  = '0;
    for (int i = 0; i < N; i++) begin
      rsp_valid[i]         = (fifo_cnt[i] != '0);
      rsp_dout[32*i +: 32] = rsp_valid[i] ? fifo_mem[i][rd_ptr[i]] : 32'h0;
    end
  end

  // Sticky flag: a tag and a multiplier output must always leave together.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)                      err_sync <= 1'b0;
    else if (exit_v != mult_dout_valid) err_sync <= 1'b1;
  end

endmodule
